cfg_chain_loader: RTL and testbench

- Upstream driver of the tile configuration shift chain.
- Accepts configuration words on a valid/ready stream and serialises them LSB-first onto the chain's shift input, qualified by the chain enable.
- After exactly CHAIN_LEN bits it pulses the chain set line so every connection/switch block latches its shifted bits.
- Sits between the bitstream source (SPI/Wishbone bridge) and the first tile's shift_in/cen/set_in.

---
 rtl/cfg_chain_loader.sv | 201 ++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Configuration shift-chain loader: streams words LSB-first onto the tile chain, then pulses set.
// Optional chain readback of the previous bitstream is built when CFG_READBACK_EN is defined.
module cfg_chain_loader #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_cen,
    output logic              cfg_shift,
    output logic              cfg_set,
    input  logic              cfg_return,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned IDX_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SET   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [CNT_W-1:0]  unclaimed_q, unclaimed_d;
    logic [31:0]       take_c;
    logic              accept_c;
    logic              in_ready_d, cen_d, shift_d, set_d, busy_d, done_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start beats abort in IDLE, abort only acts in SHIFT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bits_left_q == '0) begin
                    state_d = SET;
                end
            end
            SET:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and next-cycle output values
    always_comb begin
        word_d      = word_q;
        bit_idx_d   = bit_idx_q;
        bits_left_d = bits_left_q;
        unclaimed_d = unclaimed_q;
        cen_d       = 1'b0;
        shift_d     = cfg_shift;
        set_d       = 1'b0;
        done_d      = 1'b0;
        accept_c    = in_valid && in_ready;
        // The last word only supplies the bits the chain still needs
        take_c      = (32'(unclaimed_q) >= WORD_W) ? WORD_W : 32'(unclaimed_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    bits_left_d = CNT_W'(CHAIN_LEN);
                    unclaimed_d = CNT_W'(CHAIN_LEN);
                    word_d      = '0;
                    bit_idx_d   = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    word_d      = '0;
                    bit_idx_d   = '0;
                    bits_left_d = '0;
                    unclaimed_d = '0;
                end else if (bits_left_q == '0) begin
                    cen_d   = 1'b1;
                    shift_d = 1'b0;
                    set_d   = 1'b1;
                end else begin
                    if (bit_idx_q != '0) begin
                        cen_d       = 1'b1;
                        shift_d     = word_q[0];
                        word_d      = word_q >> 1;
                        bit_idx_d   = bit_idx_q - IDX_W'(1);
                        bits_left_d = bits_left_q - CNT_W'(1);
                    end
                    if (accept_c) begin
                        word_d      = in_data;
                        bit_idx_d   = IDX_W'(take_c);
                        unclaimed_d = unclaimed_q - CNT_W'(take_c);
                    end
                end
            end
            SET: begin
                shift_d = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
            end
        endcase

        busy_d     = (state_d != IDLE);
        // Ready when the register is empty or draining its last bit next cycle
        in_ready_d = (state_d == SHIFT) && (unclaimed_d != '0) && (bit_idx_d <= IDX_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q      <= '0;
            bit_idx_q   <= '0;
            bits_left_q <= '0;
            unclaimed_q <= '0;
            in_ready    <= 1'b0;
            cfg_cen     <= 1'b0;
            cfg_shift   <= 1'b0;
            cfg_set     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            word_q      <= word_d;
            bit_idx_q   <= bit_idx_d;
            bits_left_q <= bits_left_d;
            unclaimed_q <= unclaimed_d;
            in_ready    <= in_ready_d;
            cfg_cen     <= cen_d;
            cfg_shift   <= shift_d;
            cfg_set     <= set_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] rb_sh_q;
    logic [IDX_W-1:0]  rb_cnt_q;
    logic [WORD_W-1:0] rb_next_c;

    assign rb_next_c = {cfg_return, rb_sh_q[WORD_W-1:1]};

    // Capture the chain tail MSB-in while it moves; flush a partial group at SET
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_sh_q  <= '0;
            rb_cnt_q <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state_q == IDLE) begin
                rb_cnt_q <= '0;
            end else if (state_q == SHIFT && cfg_cen) begin
                rb_sh_q <= rb_next_c;
                if (rb_cnt_q == IDX_W'(WORD_W - 1)) begin
                    rb_data  <= rb_next_c;
                    rb_valid <= 1'b1;
                    rb_cnt_q <= '0;
                end else begin
                    rb_cnt_q <= rb_cnt_q + IDX_W'(1);
                end
            end else if (state_q == SET && rb_cnt_q != '0) begin
                // Right-align so the group keeps the same bit order as a full word
                rb_data  <= rb_sh_q >> (IDX_W'(WORD_W) - rb_cnt_q);
                rb_valid <= 1'b1;
                rb_cnt_q <= '0;
            end
        end
    end
`else
    logic unused_return;

    assign unused_return = cfg_return;
    assign rb_data       = '0;
    assign rb_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: randomized loads against a bit-stream and chain model.
module tb_cfg_chain_loader;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 40;
    localparam int unsigned PL = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start, abort, in_valid, in_ready;
    logic [W-1:0] in_data;
    logic         cfg_cen, cfg_shift, cfg_set, cfg_return, busy, done;
    logic [W-1:0] rb_data;
    logic         rb_valid;

    logic         p_start, p_in_valid, p_in_ready;
    logic [W-1:0] p_in_data;
    logic         p_cen, p_shift, p_set, p_busy, p_done;
    logic [W-1:0] p_rb_data;
    logic         p_rb_valid;

    cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_cen(cfg_cen), .cfg_shift(cfg_shift), .cfg_set(cfg_set),
        .cfg_return(cfg_return), .busy(busy), .done(done),
        .rb_data(rb_data), .rb_valid(rb_valid)
    );

    cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(PL)) u_dut_p (
        .clk(clk), .rst(rst), .start(p_start), .abort(1'b0),
        .in_data(p_in_data), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .cfg_cen(p_cen), .cfg_shift(p_shift), .cfg_set(p_set),
        .cfg_return(1'b0), .busy(p_busy), .done(p_done),
        .rb_data(p_rb_data), .rb_valid(p_rb_valid)
    );

    // Behavioural tile chain: first bit shifted in ends at chain[0], next to the return tap
    logic [L-1:0] chain, chain_init;
    logic         load_chain;
    always @(posedge clk) begin
        if (load_chain) chain <= chain_init;
        else if (cfg_cen && !cfg_set) chain <= {cfg_shift, chain[L-1:1]};
    end
    assign cfg_return = chain[0];

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] words [5];
    logic [W-1:0] pw [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_load(input int stall_after, input int stall_len, input int vprob,
                            input int abort_at, input bit noise);
        int src = 0, missed = 0, stall_left = 0, gap = 0, n_hs = 0, n_set = 0, n_done = 0;
        int first_cen = -1, set_cyc = -1, done_cyc = -1, abort_t = -1;
        bit hs, fin = 1'b0, hold_ok = 1'b1, set_ok = 1'b1, rb_quiet = 1'b1;
        logic [L-1:0] prev, expv, obsv;
        bit obs[$];
        logic [W-1:0] rbq[$];

        prev = chain;
        for (int k = 0; k < int'(L); k++) expv[k] = words[k / int'(W)][k % int'(W)];

        start    = 1'b1;
        abort    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_busy", 64'(busy), 64'(1));

        for (int t = 1; t <= 300 && !fin; t++) begin
            in_valid = (src < 5) && (stall_left == 0) && (abort_t < 0) &&
                       (int'($urandom_range(0, 99)) < vprob);
            in_data  = (src < 5) ? words[src] : W'($urandom);
            start    = noise && (abort_t < 0) && ($urandom_range(0, 3) == 0);
            abort    = noise && (cfg_set || done);
            if (abort_at >= 0 && abort_t < 0 && obs.size() == abort_at) begin
                abort   = 1'b1;
                abort_t = t;
            end
            hs = in_valid && in_ready;
            if (in_ready && !in_valid) begin
                missed++;
                if (stall_left > 0) stall_left--;
            end
            @(posedge clk); #1;
            if (hs) begin
                if (src == stall_after) stall_left = stall_len;
                src++;
                n_hs++;
            end
            if (cfg_cen && !cfg_set) begin
                if (first_cen < 0) first_cen = t;
                obs.push_back(cfg_shift);
            end else if (busy && !cfg_set && obs.size() > 0 && n_set == 0) begin
                gap++;
                if (cfg_shift !== obs[$]) hold_ok = 1'b0;
            end
            if (cfg_set) begin
                n_set++;
                set_cyc = t;
                if (!(cfg_cen && !cfg_shift && !in_ready)) set_ok = 1'b0;
            end
            if (done) begin
                n_done++;
                done_cyc = t;
            end
            if (rb_valid) rbq.push_back(rb_data);
            if (rb_valid || rb_data != '0) rb_quiet = 1'b0;
            if (t == abort_t) check("abort_idle", 64'({busy, cfg_cen, cfg_set, done}), 64'(0));
            if (done_cyc >= 0 && t == done_cyc + 1) begin
                check("idle_after_done", 64'(busy), 64'(0));
                fin = 1'b1;
            end
            if (abort_t >= 0 && t == abort_t + 20) fin = 1'b1;
        end
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;

        if (abort_at >= 0) begin
            check("abort_bits", 64'(obs.size()), 64'(abort_at));
            check("abort_no_set", 64'(n_set), 64'(0));
            check("abort_no_done", 64'(n_done), 64'(0));
        end else begin
            obsv = '0;
            foreach (obs[i]) if (i < int'(L)) obsv[i] = obs[i];
            check("load_finished", 64'(fin), 64'(1));
            check("nbits", 64'(obs.size()), 64'(L));
            check("bits", 64'(obsv), 64'(expv));
            check("chain", 64'(chain), 64'(expv));
            check("handshakes", 64'(n_hs), 64'(5));
            check("set_count", 64'(n_set), 64'(1));
            check("done_count", 64'(n_done), 64'(1));
            check("set_cycle", 64'(set_cyc), 64'(42 + missed));
            check("done_cycle", 64'(done_cyc), 64'(43 + missed));
            check("set_shape", 64'(set_ok), 64'(1));
            check("shift_hold", 64'(hold_ok), 64'(1));
            if (vprob == 100) begin
                check("first_cen", 64'(first_cen), 64'(2));
                if (stall_after >= 0) check("stall_gap", 64'(gap), 64'(stall_len));
            end
`ifdef CFG_READBACK_EN
            check("rb_count", 64'(rbq.size()), 64'(L / W));
            foreach (rbq[i]) check("rb_word", 64'(rbq[i]), 64'(prev[i*int'(W) +: W]));
`else
            check("rb_quiet", 64'(rb_quiet), 64'(1));
`endif
        end
    endtask

    task automatic run_partial();
        int src = 0, n_set = 0;
        bit hs, fin = 1'b0;
        logic [PL-1:0] expv, obsv;
        bit obs[$];

        pw[0] = 8'hFF;
        pw[1] = 8'hFF;
        pw[2] = 8'hF3;
        for (int k = 0; k < int'(PL); k++) expv[k] = pw[k / int'(W)][k % int'(W)];
        p_start = 1'b1;
        @(posedge clk); #1;
        p_start = 1'b0;
        for (int t = 1; t <= 60 && !fin; t++) begin
            p_in_valid = 1'b1;
            p_in_data  = (src < 3) ? pw[src] : 8'hEE;
            hs = p_in_valid && p_in_ready;
            @(posedge clk); #1;
            if (hs) src++;
            if (p_cen && !p_set) obs.push_back(p_shift);
            if (p_set) n_set++;
            if (p_done) fin = 1'b1;
        end
        p_in_valid = 1'b0;
        obsv = '0;
        foreach (obs[i]) if (i < int'(PL)) obsv[i] = obs[i];
        check("p_finished", 64'(fin), 64'(1));
        check("p_handshakes", 64'(src), 64'(3));
        check("p_nbits", 64'(obs.size()), 64'(PL));
        check("p_bits", 64'(obsv), 64'(expv));
        check("p_set_count", 64'(n_set), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        p_start    = 1'b0;
        p_in_valid = 1'b0;
        p_in_data  = '0;
        chain_init = 40'h01_2345_6789;
        load_chain = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, in_ready, cfg_cen, cfg_shift, cfg_set, done, rb_valid}), 64'(0));
        check("reset_rb_data", 64'(rb_data), 64'(0));
        check("reset_outputs_p", 64'({p_busy, p_in_ready, p_cen, p_shift, p_set, p_done}), 64'(0));
        rst        = 1'b1;
        load_chain = 1'b0;

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h81;
        run_load(-1, 0, 100, -1, 1'b0);

        foreach (words[i]) words[i] = W'($urandom);
        run_load(1, 5, 100, -1, 1'b0);

        run_load(-1, 0, 100, 13, 1'b0);

        foreach (words[i]) words[i] = W'($urandom);
        run_load(-1, 0, 100, -1, 1'b0);

        // Asynchronous reset in the middle of a shift
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h5A;
            @(posedge clk); #1;
        end
        check("pre_rst_cen", 64'({busy, cfg_cen}), 64'(3));
        #3 rst = 1'b0;
        #1;
        check("async_rst", 64'({busy, in_ready, cfg_cen, cfg_shift, cfg_set, done, rb_valid}), 64'(0));
        check("async_rst_rb", 64'(rb_data), 64'(0));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_rst", 64'(busy), 64'(0));
        #2 rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", 64'(busy), 64'(0));

        for (int r = 0; r < 6; r++) begin
            foreach (words[i]) words[i] = W'($urandom);
            run_load((r % 2 == 1) ? int'($urandom_range(0, 3)) : -1, int'($urandom_range(1, 6)),
                     int'($urandom_range(60, 100)), -1, 1'b1);
        end

        run_partial();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
